interconn_priority: RTL and testbench
=====================================

INTERCONN_PRIORITY -- requirements
Module: interconn_priority

Interface
REQ-001 Parameter N, default 8: number of MVU ports (senders and receivers), N >= 2.
REQ-002 Parameter W, default 64: data word width in bits.
REQ-003 Parameter BADDR, default 15: memory address width in bits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 clr  input  1  asynchronous active-low reset.
REQ-007 send_to  input  N x [N]  per-sender destination one-hot/multi-hot selector; bit r set targets receiver r.
REQ-008 send_en  input  N x 1  per-sender request valid.
REQ-009 send_addr  input  N x [BADDR]  per-sender destination memory address.
REQ-010 send_word  input  N x [W]  per-sender data word.
REQ-011 recv_from  output  N x [N]  per-receiver one-hot ID of the winning sender; 0 when idle.
REQ-012 recv_en  output  N x 1  per-receiver write strobe.
REQ-013 recv_addr  output  N x [BADDR]  per-receiver write address.
REQ-014 recv_word  output  N x [W]  per-receiver data word.

Function
REQ-015 Sender s SHALL request receiver r in a cycle iff send_en[s]=1 and send_to[s][r]=1; self-send (s=r) is legal.
REQ-016 For each receiver r independently, the winner SHALL be the lowest-indexed requesting sender (fixed priority, index 0 highest).
REQ-017 All outputs SHALL be registered; a request sampled at rising edge k SHALL appear on the receiver outputs after edge k and remain until edge k+1 (latency 1 cycle, strobe 1 cycle per request cycle).
REQ-018 On a winning cycle: recv_en[r]=1, recv_from[r]=(1<<s), recv_addr[r]=send_addr[s], recv_word[r]=send_word[s].
REQ-019 With no requester for r at an edge: recv_en[r]=0, recv_from[r]=0, recv_addr[r]=0, recv_word[r]=0.
REQ-020 A sender with several bits set in send_to SHALL be delivered (multicast) to every targeted receiver it wins, in the same cycle.
REQ-021 Losing requests SHALL be dropped silently; no backpressure, no queuing, no retry.
REQ-022 send_to, send_addr and send_word SHALL be ignored when send_en=0.
REQ-023 Back-to-back requests on consecutive cycles SHALL produce back-to-back strobes with no bubble.
REQ-024 Different receivers SHALL operate fully in parallel; N simultaneous non-conflicting transfers complete in one cycle.

Reset
REQ-025 While clr=0, all outputs SHALL be 0 immediately (asynchronously), independent of clk.
REQ-026 Requests present at the edge on which clr is low SHALL be discarded; the first delivery occurs for requests sampled at the first rising edge with clr=1.
REQ-027 The block SHALL hold no state beyond the output registers.

Structure
REQ-028 No shared package is required; N, W, BADDR are module parameters only.
REQ-029 One sub-module, interconn_prio_arb, SHALL implement the combinational N-input fixed-priority arbiter (request vector -> one-hot grant), instantiated once per receiver; the top level muxes address/word by the grant and registers the results.

Verification
REQ-030 Reset: clr=0 with all send_en=1, send_to=all-ones -> all recv_en=0, recv_from=0, recv_addr=0, recv_word=0.
REQ-031 1-to-1 sweep, N=8: for every (i,j), send_to[i]=1<<j, send_en[i]=1, addr=i+j+1, word=0xdeadbeefdeadbeef (i odd) / 0xbeefdeadbeefdead (i even), one cycle -> one cycle later recv_en[j]=1, recv_from[j]=1<<i, recv_addr[j]=i+j+1, recv_word[j]=word; all other receivers idle.
REQ-032 Conflict: senders 2, 5, 7 all target receiver 3 (addrs 0x10, 0x20, 0x30) -> recv_from[3]=0x04, recv_addr[3]=0x10; no other receiver strobes.
REQ-033 Multicast: sender 0, send_to=0xFF, addr=0x7FFF, word=0x0123456789ABCDEF -> all 8 receivers strobe with recv_from=0x01 and that addr/word.
REQ-034 Permutation: sender i targets receiver (i+1) mod 8 simultaneously -> all 8 receivers strobe in the same cycle with correct source and data.
REQ-035 Mid-operation reset: assert clr=0 while a streaming request is active -> outputs go to 0 before the next edge; strobes resume one cycle after clr=1.

Source files
------------

// File: rtl/interconn_priority_pkg.sv
// interconn_priority_pkg: default sizing shared by the interconnect top and its arbiter
package interconn_priority_pkg;
  localparam int N_DEF = 8;
  localparam int W_DEF = 64;
  localparam int BADDR_DEF = 15;
endpackage

// File: rtl/interconn_prio_arb.sv
// interconn_prio_arb: combinational fixed-priority arbiter, lowest index wins, one-hot grant
module interconn_prio_arb
  import interconn_priority_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  // two's-complement trick isolates the lowest set request bit
  assign o_gnt = i_req & (~i_req + N'(1));
endmodule

// File: rtl/interconn_priority.sv
// interconn_priority: NxN registered crossbar, per-receiver fixed-priority arbitration, multicast capable
module interconn_priority
  import interconn_priority_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int BADDR = BADDR_DEF
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [N-1:0][N-1:0]       send_to,
  input  logic [N-1:0]              send_en,
  input  logic [N-1:0][BADDR-1:0]   send_addr,
  input  logic [N-1:0][W-1:0]       send_word,
  output logic [N-1:0][N-1:0]       recv_from,
  output logic [N-1:0]              recv_en,
  output logic [N-1:0][BADDR-1:0]   recv_addr,
  output logic [N-1:0][W-1:0]       recv_word
);
  logic [N-1:0][N-1:0]     w_req;
  logic [N-1:0][N-1:0]     w_gnt;
  logic [N-1:0]            w_en;
  logic [N-1:0][BADDR-1:0] w_addr;
  logic [N-1:0][W-1:0]     w_word;
  logic [N-1:0][N-1:0]     r_from;
  logic [N-1:0]            r_en;
  logic [N-1:0][BADDR-1:0] r_addr;
  logic [N-1:0][W-1:0]     r_word;
  // transpose sender-major requests into receiver-major request vectors
  always_comb begin
    w_req = '0;
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++)
        w_req[r][s] = send_en[s] & send_to[s][r];
  end
  for (genvar g = 0; g < N; g++) begin : g_arb
    interconn_prio_arb #(.N(N)) u_arb (.i_req(w_req[g]), .o_gnt(w_gnt[g]));
  end
  // one-hot grant makes an AND-OR mux exact and zero when idle
  always_comb begin
    w_en = '0;
    w_addr = '0;
    w_word = '0;
    for (int r = 0; r < N; r++) begin
      w_en[r] = |w_req[r];
      for (int s = 0; s < N; s++) begin
        w_addr[r] = w_addr[r] | ({BADDR{w_gnt[r][s]}} & send_addr[s]);
        w_word[r] = w_word[r] | ({W{w_gnt[r][s]}} & send_word[s]);
      end
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_en <= '0;
      r_from <= '0;
      r_addr <= '0;
      r_word <= '0;
    end else begin
      r_en <= w_en;
      r_from <= w_gnt;
      r_addr <= w_addr;
      r_word <= w_word;
    end
  end
  assign recv_en = r_en;
  assign recv_from = r_from;
  assign recv_addr = r_addr;
  assign recv_word = r_word;
endmodule

// File: tb/tb_interconn_priority.sv
// tb_interconn_priority: directed vectors with hand-computed per-receiver expectations
module tb_interconn_priority;
  localparam logic [63:0] W_ODD = 64'hdeadbeefdeadbeef;
  localparam logic [63:0] W_EVEN = 64'hbeefdeadbeefdead;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [7:0][7:0]  send_to, recv_from, e_from;
  logic [7:0]       send_en, recv_en, e_en;
  logic [7:0][14:0] send_addr, recv_addr, e_addr;
  logic [7:0][63:0] send_word, recv_word, e_word;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  interconn_priority #(.N(8), .W(64), .BADDR(15)) dut (
    .clk(clk), .clr(clr),
    .send_to(send_to), .send_en(send_en), .send_addr(send_addr), .send_word(send_word),
    .recv_from(recv_from), .recv_en(recv_en), .recv_addr(recv_addr), .recv_word(recv_word)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("%s en[%0d]", tag, r), 64'(recv_en[r]), 64'(e_en[r]));
      chk($sformatf("%s from[%0d]", tag, r), 64'(recv_from[r]), 64'(e_from[r]));
      chk($sformatf("%s addr[%0d]", tag, r), 64'(recv_addr[r]), 64'(e_addr[r]));
      chk($sformatf("%s word[%0d]", tag, r), recv_word[r], e_word[r]);
    end
  endtask

  task automatic clear_exp();
    e_en = '0; e_from = '0; e_addr = '0; e_word = '0;
  endtask

  task automatic idle();
    send_en = '0; send_to = '0; send_addr = '0; send_word = '0;
    clear_exp();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // reset held with every sender requesting everything
    send_en = '1;
    send_to = '1;
    for (int s = 0; s < 8; s++) begin
      send_addr[s] = 15'(16'h0100 + s);
      send_word[s] = 64'h5555_0000_0000_0000 + 64'(s);
    end
    step();
    step();
    check_all("reset");
    // first edge after release delivers; sender 0 wins every receiver
    clr = 1'b1;
    e_en = '1;
    for (int r = 0; r < 8; r++) begin
      e_from[r] = 8'h01;
      e_addr[r] = 15'h0100;
      e_word[r] = 64'h5555_0000_0000_0000;
    end
    step();
    check_all("first");
    // 1-to-1 sweep, back-to-back vectors
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        idle();
        send_en[i] = 1'b1;
        send_to[i] = 8'(1 << j);
        send_addr[i] = 15'(i + j + 1);
        send_word[i] = (i % 2) ? W_ODD : W_EVEN;
        e_en[j] = 1'b1;
        e_from[j] = 8'(1 << i);
        e_addr[j] = 15'(i + j + 1);
        e_word[j] = (i % 2) ? W_ODD : W_EVEN;
        step();
        check_all($sformatf("sweep%0d%0d", i, j));
      end
    // conflict on receiver 3
    idle();
    send_en[2] = 1'b1; send_to[2] = 8'h08; send_addr[2] = 15'h10; send_word[2] = 64'hA2;
    send_en[5] = 1'b1; send_to[5] = 8'h08; send_addr[5] = 15'h20; send_word[5] = 64'hA5;
    send_en[7] = 1'b1; send_to[7] = 8'h08; send_addr[7] = 15'h30; send_word[7] = 64'hA7;
    e_en[3] = 1'b1; e_from[3] = 8'h04; e_addr[3] = 15'h10; e_word[3] = 64'hA2;
    step();
    check_all("conflict");
    // multicast
    idle();
    send_en[0] = 1'b1; send_to[0] = 8'hFF; send_addr[0] = 15'h7FFF; send_word[0] = 64'h0123456789ABCDEF;
    e_en = '1;
    for (int r = 0; r < 8; r++) begin
      e_from[r] = 8'h01; e_addr[r] = 15'h7FFF; e_word[r] = 64'h0123456789ABCDEF;
    end
    step();
    check_all("mcast");
    // permutation i -> i+1
    idle();
    send_en = '1;
    for (int i = 0; i < 8; i++) begin
      send_to[i] = 8'(1 << ((i + 1) % 8));
      send_addr[i] = 15'(16'h0200 + i);
      send_word[i] = 64'h1111_0000_0000_0000 + 64'(i);
      e_en[(i + 1) % 8] = 1'b1;
      e_from[(i + 1) % 8] = 8'(1 << i);
      e_addr[(i + 1) % 8] = 15'(16'h0200 + i);
      e_word[(i + 1) % 8] = 64'h1111_0000_0000_0000 + 64'(i);
    end
    step();
    check_all("perm");
    // disabled senders with live-looking payload stay invisible
    idle();
    send_to = '1;
    for (int s = 0; s < 8; s++) begin
      send_addr[s] = 15'h7ABC;
      send_word[s] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    step();
    check_all("disabled");
    // mid-operation reset while streaming 1 -> 4
    idle();
    send_en[1] = 1'b1; send_to[1] = 8'h10; send_addr[1] = 15'h55; send_word[1] = 64'hCAFE;
    e_en[4] = 1'b1; e_from[4] = 8'h02; e_addr[4] = 15'h55; e_word[4] = 64'hCAFE;
    step();
    check_all("stream");
    #2 clr = 1'b0;
    #1;
    clear_exp();
    check_all("async_clr");
    step();
    check_all("clr_edge");
    #2 clr = 1'b1;
    #1;
    check_all("pre_resume");
    e_en[4] = 1'b1; e_from[4] = 8'h02; e_addr[4] = 15'h55; e_word[4] = 64'hCAFE;
    step();
    check_all("resume");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
